// File: rtl/buffer.sv
// -----------------------------------------------------------------------------
// buffer
//   Four-lane ingress FIFO. Each cycle it accepts either one word from lane 0
//   or, in multi-width mode, four words from lanes 0..3 at once (lane 0 is
//   the oldest). It drains one word per cycle into a registered output. There
//   is no downstream backpressure; producers are throttled by the per-lane
//   ready flags and by full.
//
// Parameters
//   DATA_WIDTH  width of every lane and of out_data
//   DEPTH       number of entries, power of two and >= 4
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   in_ready     producers present valid data this cycle
//   multi_width  0: single write from in_data0, 1: four-lane write
//   in_data0..3  lane data
//   ready0..3    lane k is accepted if in_ready=1 this cycle
//   out_data     most recently drained word (registered)
//   full         count == DEPTH
// -----------------------------------------------------------------------------
module buffer #(
    parameter int unsigned DATA_WIDTH = 40,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_ready,
    input  logic                  multi_width,
    input  logic [DATA_WIDTH-1:0] in_data0,
    input  logic [DATA_WIDTH-1:0] in_data1,
    input  logic [DATA_WIDTH-1:0] in_data2,
    input  logic [DATA_WIDTH-1:0] in_data3,
    output logic                  ready0,
    output logic                  ready1,
    output logic                  ready2,
    output logic                  ready3,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  full
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned LANES = 4;

    localparam logic [CW-1:0] CNT_DEPTH     = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_MULTI_MAX = CW'(DEPTH - LANES);

    // Storage (not reset; a location is never read before it is written)
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Registered state
    logic [AW-1:0]         wp_q,    wp_d;
    logic [AW-1:0]         rp_q,    rp_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] out_q,   out_d;

    // Combinational helpers
    logic                  room_one;
    logic                  room_four;
    logic                  wr_en;
    logic                  drain;
    logic [CW-1:0]         wr_words;
    logic [DATA_WIDTH-1:0] lane     [LANES];
    logic [AW-1:0]         wr_idx   [LANES];
    logic                  lane_we  [LANES];

    // -------------------------------------------------------------------------
    // Ready flags: derived from the registered count only, so a drain in the
    // same cycle earns no credit and there is no path from in_ready/data.
    // -------------------------------------------------------------------------
    always_comb begin
        room_one  = (count_q != CNT_DEPTH);
        room_four = (count_q <= CNT_MULTI_MAX);

        ready0 = multi_width ? room_four : room_one;
        ready1 = multi_width & room_four;
        ready2 = multi_width & room_four;
        ready3 = multi_width & room_four;
    end

    // -------------------------------------------------------------------------
    // Write / drain decode and next-state
    // -------------------------------------------------------------------------
    always_comb begin
        lane[0] = in_data0;
        lane[1] = in_data1;
        lane[2] = in_data2;
        lane[3] = in_data3;

        // Writes while ready0=0 are dropped without touching any state.
        wr_en = in_ready & ready0;
        drain = (count_q != '0);

        if (!wr_en) begin
            wr_words = '0;
        end else if (multi_width) begin
            wr_words = CW'(LANES);
        end else begin
            wr_words = CW'(1);
        end

        // Consecutive slots from wp, wrapping modulo DEPTH by truncation, so
        // a four-word write straddling the array end splits with no gap.
        for (int unsigned k = 0; k < LANES; k++) begin
            wr_idx[k]  = wp_q + AW'(k);
            lane_we[k] = wr_en & (multi_width | (k == 0));
        end

        // Pointer advance truncates naturally; with DEPTH=4 a four-word
        // write leaves wp where it was, which is the correct modulo result.
        wp_d    = wp_q + wr_words[AW-1:0];
        rp_d    = rp_q + {{(AW-1){1'b0}}, drain};
        count_d = count_q + wr_words - {{AW{1'b0}}, drain};
        out_d   = drain ? mem[rp_q] : out_q;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            out_q   <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            out_q   <= out_d;
        end
    end

    // Storage write port. The drain reads mem[rp_q] only when count >= 1,
    // which never aliases the slot being written this cycle.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < LANES; k++) begin
            if (lane_we[k]) begin
                mem[wr_idx[k]] <= lane[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_data = out_q;
    assign full     = (count_q == CNT_DEPTH);

endmodule

// File: tb/tb_buffer.sv
module tb_buffer;

    localparam int DW = 40;

    logic          clk;
    // DEPTH=8 instance
    logic          rst, in_ready, multi_width;
    logic [DW-1:0] d0, d1, d2, d3;
    logic          r0, r1, r2, r3;
    logic [DW-1:0] out_data;
    logic          full;
    // DEPTH=4 instance (the only depth at which full is reachable)
    logic          rst4, in_ready4, multi4;
    logic [DW-1:0] e0, e1, e2, e3;
    logic          s0, s1, s2, s3;
    logic [DW-1:0] out4;
    logic          full4;

    int checks   = 0;
    int failures = 0;

    buffer #(.DATA_WIDTH(DW), .DEPTH(8)) u_dut (
        .clk(clk), .rst(rst), .in_ready(in_ready), .multi_width(multi_width),
        .in_data0(d0), .in_data1(d1), .in_data2(d2), .in_data3(d3),
        .ready0(r0), .ready1(r1), .ready2(r2), .ready3(r3),
        .out_data(out_data), .full(full)
    );

    buffer #(.DATA_WIDTH(DW), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst4), .in_ready(in_ready4), .multi_width(multi4),
        .in_data0(e0), .in_data1(e1), .in_data2(e2), .in_data3(e3),
        .ready0(s0), .ready1(s1), .ready2(s2), .ready3(s3),
        .out_data(out4), .full(full4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_data !== 40'h0) begin failures++; $display("FAIL reset_out: got %h exp 0", out_data); end
            checks++;
            if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b exp 0", full); end
            checks++;
            if ({r3, r2, r1, r0} !== 4'b0001) begin failures++; $display("FAIL reset_ready: got %b exp 0001", {r3, r2, r1, r0}); end
        end
        multi_width = 1'b1; #1;
        checks++;
        if ({r3, r2, r1, r0} !== 4'b1111) begin failures++; $display("FAIL reset_ready_multi: got %b exp 1111", {r3, r2, r1, r0}); end
        multi_width = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; rst4 = 1'b1;
    endtask

    task automatic test_single();
        in_ready = 1'b1; multi_width = 1'b0; d0 = 40'hA1; #1;
        checks++;
        if ({r3, r2, r1, r0} !== 4'b0001) begin failures++; $display("FAIL single_ready: got %b exp 0001", {r3, r2, r1, r0}); end
        @(posedge clk); #1;
        checks++;
        if (out_data !== 40'h0) begin failures++; $display("FAIL single_latency: got %h exp 0", out_data); end
        d0 = 40'hA2;
        @(posedge clk); #1;
        checks++;
        if (out_data !== 40'hA1) begin failures++; $display("FAIL single_first: got %h exp a1", out_data); end
        checks++;
        if (full !== 1'b0) begin failures++; $display("FAIL single_full: got %b exp 0", full); end
        in_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_data !== 40'hA2) begin failures++; $display("FAIL single_second: got %h exp a2", out_data); end
        @(posedge clk); #1;
        checks++;
        if (out_data !== 40'hA2) begin failures++; $display("FAIL single_hold: got %h exp a2", out_data); end
    endtask

    task automatic test_multi();
        multi_width = 1'b1; in_ready = 1'b1;
        d0 = 40'h10; d1 = 40'h11; d2 = 40'h12; d3 = 40'h13; #1;
        checks++;
        if ({r3, r2, r1, r0} !== 4'b1111) begin failures++; $display("FAIL multi_ready: got %b exp 1111", {r3, r2, r1, r0}); end
        @(posedge clk); #1;
        in_ready = 1'b0;
        checks++;
        if (out_data !== 40'hA2) begin failures++; $display("FAIL multi_latency: got %h exp a2", out_data); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_data !== 40'(32'h10 + i)) begin failures++; $display("FAIL multi_lane%0d: got %h exp %h", i, out_data, 40'(32'h10 + i)); end
        end
        @(posedge clk); #1;
        checks++;
        if (out_data !== 40'h13) begin failures++; $display("FAIL multi_hold: got %h exp 13", out_data); end
        checks++;
        if (full !== 1'b0) begin failures++; $display("FAIL multi_full: got %b exp 0", full); end
    endtask

    // Continuous multi-width offers; the reference count follows the ready
    // rules (accept when count <= DEPTH-4, drain when count >= 1).
    task automatic test_back_to_back();
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_out;
        int cnt;
        int grp;
        bit acc;
        bit drained;
        cnt = 0; grp = 0; exp_out = 40'h13;
        multi_width = 1'b1;
        for (int cyc = 0; cyc < 26; cyc++) begin
            in_ready = (cyc < 16);
            acc = in_ready && (cnt <= 4);
            d0 = 40'(32'h100 + grp * 4);
            d1 = 40'(32'h101 + grp * 4);
            d2 = 40'(32'h102 + grp * 4);
            d3 = 40'(32'h103 + grp * 4);
            #1;
            checks++;
            if ({r3, r2, r1, r0} !== {4{cnt <= 4}}) begin
                failures++;
                $display("FAIL b2b_ready cyc%0d: got %b exp %b", cyc, {r3, r2, r1, r0}, {4{cnt <= 4}});
            end
            @(posedge clk);
            drained = (cnt >= 1);
            if (drained) exp_out = q.pop_front();
            if (acc) begin
                q.push_back(d0); q.push_back(d1); q.push_back(d2); q.push_back(d3);
                grp++;
            end
            cnt = cnt + (acc ? 4 : 0) - (drained ? 1 : 0);
            #1;
            checks++;
            if (out_data !== exp_out) begin failures++; $display("FAIL b2b_out cyc%0d: got %h exp %h", cyc, out_data, exp_out); end
            checks++;
            if (full !== (cnt == 8)) begin failures++; $display("FAIL b2b_full cyc%0d: got %b exp %b", cyc, full, (cnt == 8)); end
        end
        in_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        multi_width = 1'b1; in_ready = 1'b1;
        d0 = 40'h200; d1 = 40'h201; d2 = 40'h202; d3 = 40'h203;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_ready = 1'b0;
        checks++;
        if (out_data !== 40'h200) begin failures++; $display("FAIL arst_pre: got %h exp 200", out_data); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (out_data !== 40'h0) begin failures++; $display("FAIL arst_out: got %h exp 0", out_data); end
        checks++;
        if (full !== 1'b0) begin failures++; $display("FAIL arst_full: got %b exp 0", full); end
        checks++;
        if ({r3, r2, r1, r0} !== 4'b1111) begin failures++; $display("FAIL arst_ready: got %b exp 1111", {r3, r2, r1, r0}); end
        multi_width = 1'b0; #1;
        checks++;
        if ({r3, r2, r1, r0} !== 4'b0001) begin failures++; $display("FAIL arst_ready_single: got %b exp 0001", {r3, r2, r1, r0}); end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_data !== 40'h0) begin failures++; $display("FAIL arst_stale%0d: got %h exp 0", i, out_data); end
        end
    endtask

    task automatic test_wrap();
        multi_width = 1'b0; in_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d0 = 40'(32'h300 + i);
            @(posedge clk); #1;
            if (i > 0) begin
                checks++;
                if (out_data !== 40'(32'h300 + i - 1)) begin failures++; $display("FAIL wrap_fill%0d: got %h exp %h", i, out_data, 40'(32'h300 + i - 1)); end
            end
        end
        in_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_data !== 40'h305) begin failures++; $display("FAIL wrap_fill_last: got %h exp 305", out_data); end
        // pointers now at index 6
        d0 = 40'h400; in_ready = 1'b1;
        @(posedge clk); #1;
        multi_width = 1'b1;
        d0 = 40'h410; d1 = 40'h411; d2 = 40'h412; d3 = 40'h413; #1;
        checks++;
        if ({r3, r2, r1, r0} !== 4'b1111) begin failures++; $display("FAIL wrap_ready: got %b exp 1111", {r3, r2, r1, r0}); end
        @(posedge clk); #1;
        in_ready = 1'b0;
        checks++;
        if (out_data !== 40'h400) begin failures++; $display("FAIL wrap_idx6: got %h exp 400", out_data); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_data !== 40'(32'h410 + i)) begin failures++; $display("FAIL wrap_lane%0d: got %h exp %h", i, out_data, 40'(32'h410 + i)); end
        end
        @(posedge clk); #1;
        checks++;
        if (out_data !== 40'h413) begin failures++; $display("FAIL wrap_hold: got %h exp 413", out_data); end
    endtask

    task automatic test_full_depth4();
        multi4 = 1'b0; in_ready4 = 1'b1; e0 = 40'h500;
        @(posedge clk); #1;
        in_ready4 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out4 !== 40'h500) begin failures++; $display("FAIL d4_single: got %h exp 500", out4); end
        multi4 = 1'b1; in_ready4 = 1'b1;
        e0 = 40'h510; e1 = 40'h511; e2 = 40'h512; e3 = 40'h513; #1;
        checks++;
        if ({s3, s2, s1, s0} !== 4'b1111) begin failures++; $display("FAIL d4_ready_empty: got %b exp 1111", {s3, s2, s1, s0}); end
        @(posedge clk); #1;
        in_ready4 = 1'b0;
        checks++;
        if (full4 !== 1'b1) begin failures++; $display("FAIL d4_full: got %b exp 1", full4); end
        checks++;
        if (out4 !== 40'h500) begin failures++; $display("FAIL d4_hold: got %h exp 500", out4); end
        checks++;
        if ({s3, s2, s1, s0} !== 4'b0000) begin failures++; $display("FAIL d4_ready_full_multi: got %b exp 0000", {s3, s2, s1, s0}); end
        multi4 = 1'b0; #1;
        checks++;
        if ({s3, s2, s1, s0} !== 4'b0000) begin failures++; $display("FAIL d4_ready_full_single: got %b exp 0000", {s3, s2, s1, s0}); end
        @(posedge clk); #1;
        checks++;
        if (out4 !== 40'h510) begin failures++; $display("FAIL d4_drain: got %h exp 510", out4); end
        checks++;
        if (full4 !== 1'b0) begin failures++; $display("FAIL d4_unfull: got %b exp 0", full4); end
        checks++;
        if ({s3, s2, s1, s0} !== 4'b0001) begin failures++; $display("FAIL d4_ready_single_back: got %b exp 0001", {s3, s2, s1, s0}); end
        multi4 = 1'b1; #1;
        checks++;
        if ({s3, s2, s1, s0} !== 4'b0000) begin failures++; $display("FAIL d4_ready_multi_wait: got %b exp 0000", {s3, s2, s1, s0}); end
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out4 !== 40'(32'h510 + i)) begin failures++; $display("FAIL d4_lane%0d: got %h exp %h", i, out4, 40'(32'h510 + i)); end
        end
        // refill to full, then reset mid-cycle
        e0 = 40'h520; e1 = 40'h521; e2 = 40'h522; e3 = 40'h523; in_ready4 = 1'b1;
        @(posedge clk); #1;
        in_ready4 = 1'b0;
        checks++;
        if (full4 !== 1'b1) begin failures++; $display("FAIL d4_refull: got %b exp 1", full4); end
        #2 rst4 = 1'b0;
        #1;
        checks++;
        if (out4 !== 40'h0) begin failures++; $display("FAIL d4_rst_out: got %h exp 0", out4); end
        checks++;
        if (full4 !== 1'b0) begin failures++; $display("FAIL d4_rst_full: got %b exp 0", full4); end
        checks++;
        if ({s3, s2, s1, s0} !== 4'b1111) begin failures++; $display("FAIL d4_rst_ready: got %b exp 1111", {s3, s2, s1, s0}); end
        @(posedge clk); #1;
        rst4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out4 !== 40'h0) begin failures++; $display("FAIL d4_stale%0d: got %h exp 0", i, out4); end
            checks++;
            if (full4 !== 1'b0) begin failures++; $display("FAIL d4_stale_full%0d: got %b exp 0", i, full4); end
        end
    endtask

    initial begin
        rst = 1'b1; rst4 = 1'b1;
        in_ready = 1'b0; multi_width = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        in_ready4 = 1'b0; multi4 = 1'b0;
        e0 = '0; e1 = '0; e2 = '0; e3 = '0;
        #1 rst = 1'b0; rst4 = 1'b0;

        test_reset();
        test_single();
        test_multi();
        test_back_to_back();
        test_async_reset();
        test_wrap();
        test_full_depth4();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
